// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage with its F/D pipeline register.
// Holds the PC, drives the instruction-memory address, and latches the fetched
// word into F/D under stall (PCwrite / F_Dwrite) and branch redirect/flush control.
// Optional feature: define FETCH_STALL_CNT_EN to build a saturating stall-cycle
// counter on stall_cnt; without it stall_cnt is tied to zero.
module fetch_stage #(
  parameter int                   PC_W      = 16,
  parameter int                   INSTR_W   = 16,
  parameter logic [PC_W-1:0]      RESET_PC  = '0,
  parameter int                   PC_INC    = 2,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               PCwrite,
  input  logic               F_Dwrite,
  input  logic               branch,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    imem_addr,
  output logic [INSTR_W-1:0] F_Dinstr,
  output logic [PC_W-1:0]    F_Dpc,
  output logic               F_Dvalid,
  output logic [3:0]         F_Dopcode,
  output logic [3:0]         F_Dop1,
  output logic [3:0]         F_Dop2,
  output logic [15:0]        stall_cnt
);

  // Increment sized to the PC so the add wraps modulo 2^PC_W.
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(PC_INC);

  logic [PC_W-1:0] pc;

  // Redirect targets are halfword aligned: the LSB is dropped.
  logic [PC_W-1:0] branch_pc;
  assign branch_pc = {branch_target[PC_W-1:1], 1'b0};

  assign imem_addr = pc;

  // PC update: branch beats stall, stall beats sequential increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch) begin
      // NOTE: state registers use non-blocking assignment so every flop samples
      // the pre-edge value of pc, which the F/D block below also reads.
      pc <= branch_pc;
    end else if (PCwrite) begin
      pc <= pc + PC_STEP;
    end
  end

  // F/D register: a branch flushes the slot even while F_Dwrite is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      F_Dinstr <= NOP_INSTR;
      F_Dpc    <= '0;
      F_Dvalid <= 1'b0;
    end else if (branch) begin
      F_Dinstr <= NOP_INSTR;
      F_Dpc    <= pc;
      F_Dvalid <= 1'b0;
    end else if (F_Dwrite) begin
      F_Dinstr <= imem_data;
      F_Dpc    <= pc;
      F_Dvalid <= 1'b1;
    end
  end

  // Field slices feed the hazard unit directly; downstream qualifies with F_Dvalid.
  assign F_Dopcode = F_Dinstr[INSTR_W-1 -: 4];
  assign F_Dop1    = F_Dinstr[INSTR_W-5 -: 4];
  assign F_Dop2    = F_Dinstr[INSTR_W-9 -: 4];

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Count edges where the PC was held by a stall; saturate rather than wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (!PCwrite && !branch && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
// The driver pushes the hand-computed post-edge state for each cycle; a monitor
// pops and compares one entry after every clock edge or reset assertion.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCwrite;
  logic        F_Dwrite;
  logic        branch;
  logic [15:0] branch_target;
  logic [15:0] imem_data;
  logic [15:0] imem_addr;
  logic [15:0] F_Dinstr;
  logic [15:0] F_Dpc;
  logic        F_Dvalid;
  logic [3:0]  F_Dopcode;
  logic [3:0]  F_Dop1;
  logic [3:0]  F_Dop2;
  logic [15:0] stall_cnt;

  // Instruction memory model: word = addr ^ A5A5 unless overridden.
  logic        imem_ovr    = 1'b0;
  logic [15:0] imem_ovr_val = 16'h0000;
  assign imem_data = imem_ovr ? imem_ovr_val : (imem_addr ^ 16'hA5A5);

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PCwrite       (PCwrite),
    .F_Dwrite      (F_Dwrite),
    .branch        (branch),
    .branch_target (branch_target),
    .imem_data     (imem_data),
    .imem_addr     (imem_addr),
    .F_Dinstr      (F_Dinstr),
    .F_Dpc         (F_Dpc),
    .F_Dvalid      (F_Dvalid),
    .F_Dopcode     (F_Dopcode),
    .F_Dop1        (F_Dop1),
    .F_Dop2        (F_Dop2),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] fdpc;
    logic        valid;
    logic [15:0] scnt;   // value expected when the counter is built in
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle's controls, queue the expected post-edge state, advance.
  task automatic step(input logic pcw, input logic fdw, input logic br, input logic [15:0] tgt,
                      input logic [15:0] e_addr, input logic [15:0] e_instr,
                      input logic [15:0] e_fdpc, input logic e_valid, input logic [15:0] e_scnt);
    exp_t e;
    PCwrite       = pcw;
    F_Dwrite      = fdw;
    branch        = br;
    branch_target = tgt;
    e.addr  = e_addr;
    e.instr = e_instr;
    e.fdpc  = e_fdpc;
    e.valid = e_valid;
    e.scnt  = e_scnt;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: every edge (clock or async reset) presents a new state to compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("imem_addr", imem_addr, e.addr);
        check("F_Dinstr",  F_Dinstr,  e.instr);
        check("F_Dpc",     F_Dpc,     e.fdpc);
        check("F_Dvalid",  {15'd0, F_Dvalid}, {15'd0, e.valid});
        check("F_Dopcode", {12'd0, F_Dopcode}, {12'd0, e.instr[15:12]});
        check("F_Dop1",    {12'd0, F_Dop1},    {12'd0, e.instr[11:8]});
        check("F_Dop2",    {12'd0, F_Dop2},    {12'd0, e.instr[7:4]});
`ifdef FETCH_STALL_CNT_EN
        check("stall_cnt", stall_cnt, e.scnt);
`else
        check("stall_cnt", stall_cnt, 16'h0000);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    PCwrite = 1'b1; F_Dwrite = 1'b1; branch = 1'b0; branch_target = 16'h0000;
    @(negedge clk);

    // Reset state while rst is held across an edge.
    step(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
    rst = 1'b0;

    // Free-run from RESET_PC.
    step(1, 1, 0, 16'h0000, 16'h0002, 16'hA5A5, 16'h0000, 1, 16'd0);
    step(1, 1, 0, 16'h0000, 16'h0004, 16'hA5A7, 16'h0002, 1, 16'd0);
    step(1, 1, 0, 16'h0000, 16'h0006, 16'hA5A1, 16'h0004, 1, 16'd0);
    step(1, 1, 0, 16'h0000, 16'h0008, 16'hA5A3, 16'h0006, 1, 16'd0);

    // Three-cycle stall at pc=8.
    step(0, 0, 0, 16'h0000, 16'h0008, 16'hA5A3, 16'h0006, 1, 16'd1);
    step(0, 0, 0, 16'h0000, 16'h0008, 16'hA5A3, 16'h0006, 1, 16'd2);
    step(0, 0, 0, 16'h0000, 16'h0008, 16'hA5A3, 16'h0006, 1, 16'd3);

    // Resume from 8.
    step(1, 1, 0, 16'h0000, 16'h000A, 16'hA5AD, 16'h0008, 1, 16'd3);

    // Branch during stall: LSB dropped, flush, counter untouched.
    step(0, 0, 1, 16'h0041, 16'h0040, 16'h0000, 16'h000A, 0, 16'd3);
    step(1, 1, 0, 16'h0000, 16'h0042, 16'hA5E5, 16'h0040, 1, 16'd3);

    // Back-to-back branches; second lands near the top of the address space.
    step(1, 1, 1, 16'h0101, 16'h0100, 16'h0000, 16'h0042, 0, 16'd3);
    step(1, 1, 1, 16'hFFFC, 16'hFFFC, 16'h0000, 16'h0100, 0, 16'd3);

    // Wrap-around FFFC -> FFFE -> 0000 -> 0002.
    step(1, 1, 0, 16'h0000, 16'hFFFE, 16'h5A59, 16'hFFFC, 1, 16'd3);
    step(1, 1, 0, 16'h0000, 16'h0000, 16'h5A5B, 16'hFFFE, 1, 16'd3);
    step(1, 1, 0, 16'h0000, 16'h0002, 16'hA5A5, 16'h0000, 1, 16'd3);
    step(1, 1, 0, 16'h0000, 16'h0004, 16'hA5A7, 16'h0002, 1, 16'd3);

    // PCwrite without F_Dwrite drops the word; F_Dwrite without PCwrite re-latches.
    step(1, 0, 0, 16'h0000, 16'h0006, 16'hA5A7, 16'h0002, 1, 16'd3);
    step(0, 1, 0, 16'h0000, 16'h0006, 16'hA5A3, 16'h0006, 1, 16'd4);

    // Field extraction on 16'h3120.
    imem_ovr_val = 16'h3120;
    imem_ovr     = 1'b1;
    step(1, 1, 0, 16'h0000, 16'h0008, 16'h3120, 16'h0006, 1, 16'd4);
    imem_ovr     = 1'b0;

    // Move to pc=0x20, then assert reset between edges.
    step(1, 1, 1, 16'h0020, 16'h0020, 16'h0000, 16'h0008, 0, 16'd4);
    #2;
    e.addr = 16'h0000; e.instr = 16'h0000; e.fdpc = 16'h0000; e.valid = 1'b0; e.scnt = 16'd0;
    exp_q.push_back(e);
    rst = 1'b1;
    step(1, 1, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 16'd0);
    rst = 1'b0;

    // First fetch after reset comes from RESET_PC.
    step(1, 1, 0, 16'h0000, 16'h0002, 16'hA5A5, 16'h0000, 1, 16'd0);

    @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
